exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline, between decode (ds) and memory (ms).
- Computes ALU results and owns the HI/LO registers.
- Runs a single-cycle multiplier and an iterative 32-cycle divider; the divider stalls the stage while busy.
- Issues the data-SRAM request, with byte enables and aligned write data, in the cycle the instruction hands off to ms. The synchronous SRAM read data is then valid while the instruction is in ms.

Parameters:
- DIV_CYCLES, 32, iterations the divider spends in BUSY. Fixed at 32 for 32-bit operands; exposed only for bench shortening.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ms_allowin  in  1  ms can accept
- es_allowin  out  1  es can accept
- ds_to_es_valid  in  1  ds has an instruction
- ds_to_es_bus  in  `DS_TO_ES_BUS_WD  fields: alu_op[11:0], md_op[3:0]{mult,multu,div,divu}, mf_op[1:0]{mfhi,mflo}, mt_op[1:0]{mthi,mtlo}, ld_op[6:0]{lwl,lwr,lw,lbu,lb,lhu,lh}, st_op[4:0]{swl,swr,sw,sh,sb}, res_from_mem, gr_we, dest[4:0], src1[31:0], src2[31:0], rt_value[31:0], pc[31:0]
- es_to_ms_valid  out  1  instruction ready for ms
- es_to_ms_bus  out  `ES_TO_MS_BUS_WD (110)  {rt_value, ld_op, res_from_mem, gr_we, dest, es_result, pc}, bit order as ms unpacks it
- es_to_ds_fw_bus  out  `ES_FW_BUS_WD (39)  {res_from_mem, gr_we, dest, es_result}
- out_es_valid  out  1  es_valid
- data_sram_en  out  1  SRAM request
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address, equal to the ALU sum
- data_sram_wdata  out  32  aligned store data

Interface decision: one clock; reset is asynchronous and active-high. The ports are named clk and reset.

Behaviour:
- Reset (async): es_valid=0, HI=LO=0, divider FSM=IDLE, counter=0. Consequences: es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0, es_allowin=1.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - When es_allowin, es_valid <= ds_to_es_valid.
  - The bus is captured only on ds_to_es_valid && es_allowin.
  - es_to_ms_valid = es_valid && es_ready_go.
  - "Fire" means es_to_ms_valid && ms_allowin.
- es_ready_go = 1, except for a div/divu that has not yet reached DONE.
- es_result:
  - mfhi gives HI; mflo gives LO.
  - Otherwise es_result is the ALU output (the ALU sum for loads and stores).
- Multiplier:
  - mult/multu: combinational 64-bit product, signed or unsigned.
  - {HI,LO} is written at fire.
  - Zero stall.
- mthi/mtlo write src1 into HI or LO at fire.
- HI/LO are written only at fire, so a following mfhi/mflo in es always sees the committed value.
- Divider FSM:
  - IDLE -> BUSY when es_valid && div op. Latch |src1| and |src2| plus the sign bits; counter=0.
  - BUSY: one restoring step per cycle; counter++. At counter==DIV_CYCLES-1, go to DONE.
  - DONE: es_ready_go=1. Quotient sign = s1^s2; remainder sign = s1. {HI,LO} = {rem, quo} is written at fire; the FSM returns to IDLE at fire.
  - Latency: 33 cycles from arrival in es to first possible fire.
  - If ms_allowin=0 in DONE, hold DONE with results stable.
  - Divide by zero: no exception; still takes 32 cycles. divu x/0 gives LO=32'hFFFFFFFF, HI=x.
  - Reset mid-divide aborts to IDLE with no HI/LO write.
- Memory request:
  - data_sram_en = es_valid && es_ready_go && ms_allowin && (any ld_op or st_op).
  - Address offset off = alu[1:0].
- Byte enables, gated by en:
  - sb: 1<<off.
  - sh: off0 -> 0011, off2 -> 1100.
  - sw: 1111.
  - Loads: 0000.
- Write data:
  - sb: byte replicated x4.
  - sh: halfword replicated x2.
  - sw: rt.
- Misaligned sh/sw: no check; addresses are assumed aligned by software (no AdES in this lab).
- Forward bus: gr_we field = es_gr_we && es_valid. res_from_mem tells ds to stall on a load-use hazard.

Optional Feature:
- Macro: ES_UNALIGNED_STORE_EN.
- Defined, swl byte enables: off0..3 = 0001/0011/0111/1111; wdata = rt >> 8*(3-off).
- Defined, swr byte enables: off0..3 = 1111/1110/1100/1000; wdata = rt << 8*off.
- Defined: lwl/lwr pass through ld_op unchanged.
- Undefined: swl/swr force wen=0 and en=0, and lwl/lwr bits are cleared in es_to_ms_bus. Both act as no-ops that still write rt to GPR if gr_we is set.

Decomposition:
- mycpu.h holds DS_TO_ES_BUS_WD, ES_TO_MS_BUS_WD, ES_FW_BUS_WD, and the op-field bit positions.
- Sub-module: div_iter (FSM + counter + restoring datapath).
  - Ports: clk, reset, start, signed, x, y, busy, done, ack, quo, rem.
- The existing alu module is instantiated unchanged.

Test Plan:
- addu 3+4 with ms_allowin=1: fires next cycle; es_result=7; data_sram_en=0.
- sb rt=0x000000AB at addr 0x1002: en=1, wen=0100, wdata=0xABABABAB in the fire cycle only.
- div -7/2: es_allowin=0 for 32 cycles; fire on cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following mflo yields 0xFFFFFFFD.
- divu 5/0 with ms_allowin held 0 for 3 cycles after DONE: stays DONE; then LO=0xFFFFFFFF, HI=5.
- multu 0xFFFFFFFF*2: HI=1, LO=0xFFFFFFFE, zero stall. Separately, assert reset at divider cycle 10: es_valid=0, HI/LO unchanged from reset=0.
- ES_UNALIGNED_STORE_EN on: swr rt=0x11223344 at off1 gives wen=1110, wdata=0x22334400. With the macro off: wen=0000, en=0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Execute-stage shared definitions: bus widths, op-field bit positions, divider states and the ALU.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 167;
  localparam int unsigned ES_TO_MS_BUS_WD = 110;
  localparam int unsigned ES_FW_BUS_WD    = 39;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  localparam int unsigned MD_DIVU  = 0;
  localparam int unsigned MD_DIV   = 1;
  localparam int unsigned MD_MULTU = 2;
  localparam int unsigned MD_MULT  = 3;
  localparam int unsigned MF_MFLO  = 0;
  localparam int unsigned MF_MFHI  = 1;
  localparam int unsigned MT_MTLO  = 0;
  localparam int unsigned MT_MTHI  = 1;

  localparam int unsigned ST_SB  = 0;
  localparam int unsigned ST_SH  = 1;
  localparam int unsigned ST_SW  = 2;
  localparam int unsigned ST_SWR = 3;
  localparam int unsigned ST_SWL = 4;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [3:0]  md_op;
    logic [1:0]  mf_op;
    logic [1:0]  mt_op;
    logic [6:0]  ld_op;
    logic [4:0]  st_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

  // One-hot op; shifts take the amount from a and the value from b.
  function automatic logic [31:0] alu_calc(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (op[ALU_ADD])  r |= a + b;
    if (op[ALU_SUB])  r |= a - b;
    if (op[ALU_SLT])  r |= {31'b0, $signed(a) < $signed(b)};
    if (op[ALU_SLTU]) r |= {31'b0, a < b};
    if (op[ALU_AND])  r |= a & b;
    if (op[ALU_NOR])  r |= ~(a | b);
    if (op[ALU_OR])   r |= a | b;
    if (op[ALU_XOR])  r |= a ^ b;
    if (op[ALU_SLL])  r |= b << a[4:0];
    if (op[ALU_SRL])  r |= b >> a[4:0];
    if (op[ALU_SRA])  r |= 32'($signed(b) >>> a[4:0]);
    if (op[ALU_LUI])  r |= {b[15:0], 16'b0};
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, sign fix-up on output.
module exe_stage_div_iter
  import exe_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_ack,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);
  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  div_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_rem, r_quo, r_div;
  logic            r_s1, r_s2;
  logic [31:0]     w_abs_x, w_abs_y, w_sub;
  logic [32:0]     w_shift;
  logic            w_ge;

  assign w_abs_x = (i_signed && i_x[31]) ? (~i_x + 32'd1) : i_x;
  assign w_abs_y = (i_signed && i_y[31]) ? (~i_y + 32'd1) : i_y;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_sub   = 32'(w_shift - {1'b0, r_div});

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      DivIdle: if (i_start) w_state_d = DivBusy;
      DivBusy: if (r_cnt == CntW'(DIV_CYCLES - 1)) w_state_d = DivDone;
      DivDone: if (i_ack) w_state_d = DivIdle;
      default: w_state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DivIdle;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == DivIdle && i_start) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= w_abs_x;
        r_div <= w_abs_y;
        r_s1  <= i_signed & i_x[31];
        r_s2  <= i_signed & i_y[31];
      end else if (r_state == DivBusy) begin
        r_cnt <= r_cnt + CntW'(1);
        r_rem <= w_ge ? w_sub : w_shift[31:0];
        r_quo <= {r_quo[30:0], w_ge};
      end
    end
  end

  assign o_busy = (r_state == DivBusy);
  assign o_done = (r_state == DivDone);
  assign o_quo  = (r_s1 ^ r_s2) ? (~r_quo + 32'd1) : r_quo;
  assign o_rem  = r_s1 ? (~r_rem + 32'd1) : r_rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO with multiplier and iterative divider, data-SRAM request.
// Define ES_UNALIGNED_STORE_EN to enable swl/swr stores and lwl/lwr pass-through.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FW_BUS_WD-1:0]    es_to_ds_fw_bus,
  output logic                       out_es_valid,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
`ifdef ES_UNALIGNED_STORE_EN
  localparam logic [6:0] LdMask = 7'h7f;
  localparam logic [4:0] StMask = 5'h1f;
`else
  localparam logic [6:0] LdMask = 7'h1f;
  localparam logic [4:0] StMask = 5'h07;
`endif

  logic        r_es_valid;
  ds_to_es_t   r_bus;
  logic [31:0] r_hi, r_lo;
  logic        w_is_div, w_is_mul, w_ready_go, w_fire, w_div_start, w_div_busy, w_div_done;
  logic        w_mem_op;
  logic [31:0] w_alu_res, w_es_result, w_div_quo, w_div_rem, w_wdata;
  logic [63:0] w_prod;
  logic [6:0]  w_ld_op;
  logic [4:0]  w_st_op;
  logic [1:0]  w_off;
  logic [3:0]  w_wen;

  assign w_is_div    = r_bus.md_op[MD_DIV] | r_bus.md_op[MD_DIVU];
  assign w_is_mul    = r_bus.md_op[MD_MULT] | r_bus.md_op[MD_MULTU];
  assign w_ready_go  = !w_is_div || w_div_done;
  assign es_allowin  = !r_es_valid || (w_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_ready_go;
  assign w_fire      = es_to_ms_valid && ms_allowin;
  assign w_div_start = r_es_valid && w_is_div && !w_div_busy && !w_div_done;
  assign out_es_valid = r_es_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (es_allowin) r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) r_bus <= ds_to_es_bus;
    end
  end

  assign w_alu_res = alu_calc(r_bus.alu_op, r_bus.src1, r_bus.src2);
  assign w_prod = {{32{r_bus.md_op[MD_MULT] & r_bus.src1[31]}}, r_bus.src1} *
                  {{32{r_bus.md_op[MD_MULT] & r_bus.src2[31]}}, r_bus.src2};

  exe_stage_div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_div_start),
    .i_signed(r_bus.md_op[MD_DIV]),
    .i_x     (r_bus.src1),
    .i_y     (r_bus.src2),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .i_ack   (w_fire),
    .o_quo   (w_div_quo),
    .o_rem   (w_div_rem)
  );

  // HI/LO only change at fire so a younger mfhi/mflo never sees a half-finished op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fire) begin
      if (w_is_mul) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (w_is_div) begin
        r_hi <= w_div_rem;
        r_lo <= w_div_quo;
      end else begin
        if (r_bus.mt_op[MT_MTHI]) r_hi <= r_bus.src1;
        if (r_bus.mt_op[MT_MTLO]) r_lo <= r_bus.src1;
      end
    end
  end

  assign w_es_result = r_bus.mf_op[MF_MFHI] ? r_hi :
                       r_bus.mf_op[MF_MFLO] ? r_lo : w_alu_res;

  assign w_ld_op  = r_bus.ld_op & LdMask;
  assign w_st_op  = r_bus.st_op & StMask;
  assign w_off    = w_alu_res[1:0];
  assign w_mem_op = (|w_ld_op) || (|w_st_op);

  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = r_bus.rt_value;
    if (w_st_op[ST_SB]) begin
      w_wen   = 4'b0001 << w_off;
      w_wdata = {4{r_bus.rt_value[7:0]}};
    end else if (w_st_op[ST_SH]) begin
      w_wen   = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{r_bus.rt_value[15:0]}};
    end else if (w_st_op[ST_SW]) begin
      w_wen   = 4'b1111;
    end else if (w_st_op[ST_SWL]) begin
      w_wen   = 4'b1111 >> (2'd3 - w_off);
      w_wdata = r_bus.rt_value >> {2'd3 - w_off, 3'b000};
    end else if (w_st_op[ST_SWR]) begin
      w_wen   = 4'b1111 << w_off;
      w_wdata = r_bus.rt_value << {w_off, 3'b000};
    end
  end

  assign data_sram_en    = r_es_valid && w_ready_go && ms_allowin && w_mem_op;
  assign data_sram_wen   = data_sram_en ? w_wen : 4'b0000;
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = w_wdata;

  assign es_to_ms_bus = {r_bus.rt_value, w_ld_op, r_bus.res_from_mem, r_bus.gr_we, r_bus.dest,
                         w_es_result, r_bus.pc};
  assign es_to_ds_fw_bus = {r_bus.res_from_mem, r_bus.gr_we && r_es_valid, r_bus.dest,
                            w_es_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for single-cycle ops, hand sequences for HI/LO paths.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_FW_BUS_WD-1:0]    es_to_ds_fw_bus;
  logic                       out_es_valid;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  always #5 clk = ~clk;

  exe_stage #(
    .DIV_CYCLES(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ms_allowin     (ms_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_to_ds_fw_bus(es_to_ds_fw_bus),
    .out_es_valid   (out_es_valid),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  localparam logic [11:0] A_ADD  = 12'b1 << ALU_ADD;
  localparam logic [11:0] A_SUB  = 12'b1 << ALU_SUB;
  localparam logic [11:0] A_SLT  = 12'b1 << ALU_SLT;
  localparam logic [11:0] A_SLTU = 12'b1 << ALU_SLTU;
  localparam logic [11:0] A_NOR  = 12'b1 << ALU_NOR;
  localparam logic [11:0] A_OR   = 12'b1 << ALU_OR;
  localparam logic [11:0] A_SLL  = 12'b1 << ALU_SLL;
  localparam logic [11:0] A_SRA  = 12'b1 << ALU_SRA;
  localparam logic [11:0] A_LUI  = 12'b1 << ALU_LUI;

  typedef struct packed {
    ds_to_es_t   bus;
    logic [31:0] res;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic        chk_wd;
    logic [6:0]  ld;
  } vec_t;

  vec_t vecs [16];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;

  function automatic ds_to_es_t mk(input logic [11:0] alu, input logic [3:0] md,
                                   input logic [1:0] mf, input logic [1:0] mt,
                                   input logic [6:0] ld, input logic [4:0] st,
                                   input logic [31:0] s1, input logic [31:0] s2,
                                   input logic [31:0] rt);
    ds_to_es_t b;
    b = '0;
    b.alu_op = alu; b.md_op = md; b.mf_op = mf; b.mt_op = mt;
    b.ld_op = ld; b.st_op = st;
    b.res_from_mem = |ld;
    b.gr_we = !(|st) && !(|md) && !(|mt);
    b.dest = 5'd9;
    b.src1 = s1; b.src2 = s2; b.rt_value = rt;
    b.pc = 32'hbfc0_0100;
    return b;
  endfunction

  function automatic vec_t mkv(input ds_to_es_t b, input logic [31:0] res, input logic en,
                               input logic [3:0] wen, input logic [31:0] wd, input logic chk_wd,
                               input logic [6:0] ld);
    vec_t v;
    v.bus = b; v.res = res; v.en = en; v.wen = wen; v.wd = wd; v.chk_wd = chk_wd; v.ld = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input int idx, input logic act, input logic exp);
    chk(nm, idx, {31'b0, act}, {31'b0, exp});
  endtask

  // Presents one instruction and returns just after it has been captured into es.
  task automatic issue(input ds_to_es_t b);
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (es_to_ms_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic mf_check(input string nm, input logic [1:0] mf, input logic [31:0] exp);
    issue(mk(12'b0, 4'b0, mf, 2'b0, 7'b0, 5'b0, 32'd0, 32'd0, 32'd0));
    chk(nm, 0, es_to_ms_bus[63:32], exp);
  endtask

  initial begin
    reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;

    vecs[0]  = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd3, 32'd4, 32'd0),
                   32'd7, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[1]  = mkv(mk(A_SUB, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd10, 32'd13, 32'd0),
                   32'hffff_fffd, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[2]  = mkv(mk(A_SLT, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'hffff_ffff, 32'd1, 32'd0),
                   32'd1, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[3]  = mkv(mk(A_SLTU, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd1, 32'hffff_ffff, 32'd0),
                   32'd1, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[4]  = mkv(mk(A_OR, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'h0f0, 32'h00f, 32'd0),
                   32'h0ff, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[5]  = mkv(mk(A_NOR, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd0, 32'd0, 32'd0),
                   32'hffff_ffff, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[6]  = mkv(mk(A_SLL, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd4, 32'd1, 32'd0),
                   32'h10, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[7]  = mkv(mk(A_SRA, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd4, 32'h8000_0000, 32'd0),
                   32'hf800_0000, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[8]  = mkv(mk(A_LUI, 4'b0, 2'b0, 2'b0, 7'b0, 5'b0, 32'd0, 32'h1234, 32'd0),
                   32'h1234_0000, 1'b0, 4'b0, 32'd0, 1'b0, 7'b0);
    vecs[9]  = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b00001, 32'h1000, 32'd2, 32'h0000_00ab),
                   32'h1002, 1'b1, 4'b0100, 32'habab_abab, 1'b1, 7'b0);
    vecs[10] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b00010, 32'h2000, 32'd2, 32'h0000_1234),
                   32'h2002, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 7'b0);
    vecs[11] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b00100, 32'h3000, 32'd0, 32'hdead_beef),
                   32'h3000, 1'b1, 4'b1111, 32'hdead_beef, 1'b1, 7'b0);
    vecs[12] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0010000, 5'b0, 32'h4000, 32'd4, 32'd0),
                   32'h4004, 1'b1, 4'b0000, 32'd0, 1'b0, 7'b0010000);
`ifdef ES_UNALIGNED_STORE_EN
    vecs[13] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b01000, 32'h5000, 32'd1, 32'h1122_3344),
                   32'h5001, 1'b1, 4'b1110, 32'h2233_4400, 1'b1, 7'b0);
    vecs[14] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b10000, 32'h5000, 32'd2, 32'h1122_3344),
                   32'h5002, 1'b1, 4'b0111, 32'h0011_2233, 1'b1, 7'b0);
    vecs[15] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b1000000, 5'b0, 32'h6000, 32'd3, 32'd0),
                   32'h6003, 1'b1, 4'b0000, 32'd0, 1'b0, 7'b1000000);
`else
    vecs[13] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b01000, 32'h5000, 32'd1, 32'h1122_3344),
                   32'h5001, 1'b0, 4'b0000, 32'd0, 1'b0, 7'b0);
    vecs[14] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b10000, 32'h5000, 32'd2, 32'h1122_3344),
                   32'h5002, 1'b0, 4'b0000, 32'd0, 1'b0, 7'b0);
    vecs[15] = mkv(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b1000000, 5'b0, 32'h6000, 32'd3, 32'd0),
                   32'h6003, 1'b0, 4'b0000, 32'd0, 1'b0, 7'b0);
`endif

    #12;
    chkb("rst_valid", 0, es_to_ms_valid, 1'b0);
    chkb("rst_es_valid", 0, out_es_valid, 1'b0);
    chkb("rst_en", 0, data_sram_en, 1'b0);
    chk("rst_wen", 0, {28'b0, data_sram_wen}, 32'd0);
    chkb("rst_allowin", 0, es_allowin, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].bus);
      chkb("vec_valid", i, es_to_ms_valid, 1'b1);
      chk("vec_result", i, es_to_ms_bus[63:32], vecs[i].res);
      chk("vec_fw_result", i, es_to_ds_fw_bus[31:0], vecs[i].res);
      chkb("vec_fw_gr_we", i, es_to_ds_fw_bus[37], vecs[i].bus.gr_we);
      chk("vec_ld_op", i, {25'b0, es_to_ms_bus[77:71]}, {25'b0, vecs[i].ld});
      chkb("vec_en", i, data_sram_en, vecs[i].en);
      chk("vec_wen", i, {28'b0, data_sram_wen}, {28'b0, vecs[i].wen});
      if (vecs[i].en) chk("vec_addr", i, data_sram_addr, vecs[i].res);
      if (vecs[i].chk_wd) chk("vec_wdata", i, data_sram_wdata, vecs[i].wd);
    end

    // Store request only in the fire cycle, and only when ms can accept.
    issue(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b00001, 32'h1000, 32'd2, 32'h0000_00ab));
    chkb("sb_en_fire", 0, data_sram_en, 1'b1);
    @(negedge clk);
    #1;
    chkb("sb_en_after", 0, data_sram_en, 1'b0);
    chkb("sb_es_valid_after", 0, out_es_valid, 1'b0);
    chkb("fw_gr_we_idle", 0, es_to_ds_fw_bus[37], 1'b0);
    ms_allowin = 1'b0;
    issue(mk(A_ADD, 4'b0, 2'b0, 2'b0, 7'b0, 5'b00100, 32'h3000, 32'd4, 32'h1234_5678));
    chkb("bp_valid", 0, es_to_ms_valid, 1'b1);
    chkb("bp_en", 0, data_sram_en, 1'b0);
    chkb("bp_allowin", 0, es_allowin, 1'b0);
    ms_allowin = 1'b1;
    #1;
    chkb("bp_en_release", 0, data_sram_en, 1'b1);
    chk("bp_wen_release", 0, {28'b0, data_sram_wen}, 32'hf);

    // Signed divide: 33 cycles to first fire, then HI/LO visible to mflo/mfhi.
    issue(mk(12'b0, 4'b0010, 2'b0, 2'b0, 7'b0, 5'b0, 32'hffff_fff9, 32'd2, 32'd0));
    chkb("div_stall_allowin", 0, es_allowin, 1'b0);
    wait_valid(100, lat);
    chk("div_latency", 0, 32'(lat), 32'd33);
    chkb("div_done_allowin", 0, es_allowin, 1'b1);
    mf_check("div_mflo", 2'b01, 32'hffff_fffd);
    mf_check("div_mfhi", 2'b10, 32'hffff_ffff);

    // divu by zero, held in DONE by ms back-pressure.
    issue(mk(12'b0, 4'b0001, 2'b0, 2'b0, 7'b0, 5'b0, 32'd5, 32'd0, 32'd0));
    ms_allowin = 1'b0;
    wait_valid(100, lat);
    chk("divu0_latency", 0, 32'(lat), 32'd33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chkb("divu0_hold_valid", k, es_to_ms_valid, 1'b1);
      chkb("divu0_hold_allowin", k, es_allowin, 1'b0);
    end
    ms_allowin = 1'b1;
    mf_check("divu0_mflo", 2'b01, 32'hffff_ffff);
    mf_check("divu0_mfhi", 2'b10, 32'd5);

    // Multiplies and moves into HI/LO.
    issue(mk(12'b0, 4'b0100, 2'b0, 2'b0, 7'b0, 5'b0, 32'hffff_ffff, 32'd2, 32'd0));
    chkb("multu_no_stall", 0, es_to_ms_valid, 1'b1);
    mf_check("multu_mfhi", 2'b10, 32'd1);
    mf_check("multu_mflo", 2'b01, 32'hffff_fffe);
    issue(mk(12'b0, 4'b1000, 2'b0, 2'b0, 7'b0, 5'b0, 32'hffff_fffd, 32'd5, 32'd0));
    mf_check("mult_mfhi", 2'b10, 32'hffff_ffff);
    mf_check("mult_mflo", 2'b01, 32'hffff_fff1);
    issue(mk(12'b0, 4'b0, 2'b0, 2'b10, 7'b0, 5'b0, 32'hcafe_f00d, 32'd0, 32'd0));
    mf_check("mthi_mfhi", 2'b10, 32'hcafe_f00d);
    issue(mk(12'b0, 4'b0, 2'b0, 2'b01, 7'b0, 5'b0, 32'h1234_5678, 32'd0, 32'd0));
    mf_check("mtlo_mflo", 2'b01, 32'h1234_5678);

    // Reset in the middle of a divide aborts it without touching HI/LO beyond reset.
    issue(mk(12'b0, 4'b0010, 2'b0, 2'b0, 7'b0, 5'b0, 32'd100, 32'd7, 32'd0));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chkb("rstdiv_es_valid", 0, out_es_valid, 1'b0);
    chkb("rstdiv_allowin", 0, es_allowin, 1'b1);
    chkb("rstdiv_valid", 0, es_to_ms_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mf_check("rstdiv_mfhi", 2'b10, 32'd0);
    mf_check("rstdiv_mflo", 2'b01, 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
